// File: rtl/mips_mem_pkg.sv
// Shared encodings for the fetch/data memory port: access sizes, arbiter FSM states
// and the default byte-address width of the 512x8 memory.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Size code 2'b11 is an alias for a word access.
  function automatic logic [2:0] size_beats(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_beats = 3'd1;
      SZ_HALF: size_beats = 3'd2;
      default: size_beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_serializer.sv
// Splits one access into big-endian byte beats on the byte-wide memory;
// owns the beat counter, address increment, read assembly and write lane select.
import mips_mem_pkg::*;

module mem_byte_serializer #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start_i,
  input  logic              xfer_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        nbeats_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  output logic              last_o,
  output logic              we_o,
  output logic [31:0]       asm_nxt_o
);

  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [2:0]        nbeats_q;
  logic [1:0]        beat_q;
  logic [23:0]       asm_q;
  logic [1:0]        lane;
  logic [7:0]        wbyte;

  always_ff @(posedge clk) begin
    if (clr) begin
      base_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      nbeats_q <= '0;
      beat_q   <= '0;
      asm_q    <= '0;
    end else if (start_i) begin
      base_q   <= addr_i;
      we_q     <= we_i;
      wdata_q  <= wdata_i;
      nbeats_q <= nbeats_i;
      beat_q   <= '0;
      asm_q    <= '0;
    end else if (xfer_i) begin
      beat_q   <= beat_q + 2'd1;
      asm_q    <= asm_nxt_o[23:0];
    end
  end

  // Earlier bytes are more significant; zero-seeded so short reads come out zero-extended.
  assign asm_nxt_o = {asm_q, mem_rdata_i};

  assign lane = 2'(nbeats_q - 3'd1 - {1'b0, beat_q});

  always_comb begin
    wbyte = 8'h00;
    case (lane)
      2'd0: wbyte = wdata_q[7:0];
      2'd1: wbyte = wdata_q[15:8];
      2'd2: wbyte = wdata_q[23:16];
      2'd3: wbyte = wdata_q[31:24];
      default: wbyte = 8'h00;
    endcase
  end

  assign last_o      = xfer_i & ({1'b0, beat_q} == (nbeats_q - 3'd1));
  assign mem_addr_o  = xfer_i ? (base_q + ADDR_W'(beat_q)) : '0;
  assign mem_we_o    = xfer_i & we_q;
  assign mem_wdata_o = (xfer_i & we_q) ? wbyte : 8'h00;
  assign we_o        = we_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide memory between fetch and MEM stage: data port has priority
// until fetch has lost STARVE_MAX arbitrations in a row.
import mips_mem_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              stall
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  state_e      state_q;
  logic [SW-1:0] starve_q;
  logic        win_dm_q;
  logic        if_ack_q, dm_ack_q;
  logic [31:0] if_rdata_q, dm_rdata_q;

  logic        start, grant_dm, last, xfer_we;
  logic [31:0] asm_nxt;

  assign start    = (state_q == ST_IDLE) & (if_req | dm_req);
  assign grant_dm = dm_req & ~(if_req & (starve_q == SW'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      win_dm_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      if (!if_req) starve_q <= '0;
      case (state_q)
        ST_IDLE: if (start) begin
          win_dm_q <= grant_dm;
          state_q  <= ST_XFER;
          if (grant_dm && if_req) starve_q <= starve_q + SW'(1);
          else if (!grant_dm)     starve_q <= '0;
        end
        ST_XFER: if (last) begin
          state_q <= ST_RESP;
          // Capture the fully shifted word so rdata is valid alongside the ack.
          if (win_dm_q) begin
            dm_ack_q <= 1'b1;
            if (!xfer_we) dm_rdata_q <= asm_nxt;
          end else begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= asm_nxt;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_byte_serializer #(.ADDR_W(ADDR_W)) u_ser (
    .clk         (clk),
    .clr         (clr),
    .start_i     (start),
    .xfer_i      (state_q == ST_XFER),
    .addr_i      (grant_dm ? dm_addr : if_addr),
    .we_i        (grant_dm & dm_we),
    .wdata_i     (dm_wdata),
    .nbeats_i    (grant_dm ? size_beats(dm_size) : 3'd4),
    .mem_rdata_i (mem_rdata),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .last_o      (last),
    .we_o        (xfer_we),
    .asm_nxt_o   (asm_nxt)
  );

  assign if_ack   = if_ack_q;
  assign dm_ack   = dm_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign stall    = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 512x8 memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        clr, preload;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_we, stall;
  logic [8:0]  if_addr, dm_addr, mem_addr;
  logic [1:0]  dm_size;
  logic [31:0] if_rdata, dm_rdata, dm_wdata;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  tb_mem [512];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) tb_mem[i] <= 8'h00;
      tb_mem[0] <= 8'h8C;
      tb_mem[1] <= 8'h01;
      tb_mem[2] <= 8'h00;
      tb_mem[3] <= 8'h04;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = tb_mem[mem_addr];

  mem_port_arbiter dut (
    .clk(clk), .clr(clr),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, "_if_ack"},   {31'b0, if_ack},   32'h0);
    chk({tag, "_dm_ack"},   {31'b0, dm_ack},   32'h0);
    chk({tag, "_mem_we"},   {31'b0, mem_we},   32'h0);
    chk({tag, "_mem_wd"},   {24'b0, mem_wdata}, 32'h0);
    chk({tag, "_mem_addr"}, {23'b0, mem_addr}, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata,          32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata,          32'h0);
  endtask

  initial begin
    string seq, exp_seq;
    int    cyc;

    clr = 1'b1; preload = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
    tick();
    clr = 1'b0; preload = 1'b0;
    quiet_outputs("reset");
    chk("reset_stall", {31'b0, stall}, 32'h0);

    // Word fetch at 0: beats in cycles 1-4, ack in cycle 5.
    if_req = 1'b1; if_addr = 9'd0; #1;
    chk("fetch_stall_c0", {31'b0, stall}, 32'h1);
    tick();
    chk("fetch_addr_c1", {23'b0, mem_addr}, 32'd0);
    chk("fetch_we_c1",   {31'b0, mem_we},   32'h0);
    tick(); tick(); tick();
    chk("fetch_addr_c4",  {23'b0, mem_addr}, 32'd3);
    chk("fetch_stall_c4", {31'b0, stall},    32'h1);
    chk("fetch_ack_c4",   {31'b0, if_ack},   32'h0);
    tick();
    chk("fetch_ack_c5",   {31'b0, if_ack},   32'h1);
    chk("fetch_rdata",    if_rdata,          32'h8C010004);
    chk("fetch_stall_c5", {31'b0, stall},    32'h0);
    chk("fetch_mem_addr_resp", {23'b0, mem_addr}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("fetch_ack_c6",   {31'b0, if_ack},   32'h0);
    chk("fetch_rdata_hold", if_rdata,        32'h8C010004);

    // Halfword load at 2.
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b01; dm_addr = 9'd2;
    tick(); tick();
    chk("half_ack_c2", {31'b0, dm_ack}, 32'h0);
    tick();
    chk("half_ack_c3", {31'b0, dm_ack}, 32'h1);
    chk("half_rdata",  dm_rdata,        32'h00000004);
    dm_req = 1'b0;
    tick();

    // Byte store at 511.
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b00; dm_addr = 9'd511; dm_wdata = 32'h000000AB;
    tick();
    chk("bst_we",    {31'b0, mem_we},    32'h1);
    chk("bst_addr",  {23'b0, mem_addr},  32'd511);
    chk("bst_wdata", {24'b0, mem_wdata}, 32'hAB);
    tick();
    chk("bst_ack",   {31'b0, dm_ack},    32'h1);
    chk("bst_we_c2", {31'b0, mem_we},    32'h0);
    chk("bst_rdata_hold", dm_rdata,      32'h00000004);
    dm_req = 1'b0;
    tick();
    chk("bst_mem511", {24'b0, tb_mem[511]}, 32'hAB);

    // Word store at 510 wraps to 0, 1.
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10; dm_addr = 9'd510; dm_wdata = 32'h11223344;
    tick();
    chk("wst_addr_b0", {23'b0, mem_addr},  32'd510);
    chk("wst_wd_b0",   {24'b0, mem_wdata}, 32'h11);
    tick();
    chk("wst_addr_b1", {23'b0, mem_addr},  32'd511);
    chk("wst_wd_b1",   {24'b0, mem_wdata}, 32'h22);
    tick();
    chk("wst_addr_b2", {23'b0, mem_addr},  32'd0);
    chk("wst_wd_b2",   {24'b0, mem_wdata}, 32'h33);
    tick();
    chk("wst_addr_b3", {23'b0, mem_addr},  32'd1);
    chk("wst_wd_b3",   {24'b0, mem_wdata}, 32'h44);
    tick();
    chk("wst_ack", {31'b0, dm_ack}, 32'h1);
    dm_req = 1'b0;
    tick();
    chk("wst_mem", {tb_mem[510], tb_mem[511], tb_mem[0], tb_mem[1]}, 32'h11223344);

    // Misaligned word load across the wrap, size code 11 acts as word.
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b11; dm_addr = 9'd510;
    tick(); tick(); tick(); tick(); tick();
    chk("wld_ack",   {31'b0, dm_ack}, 32'h1);
    chk("wld_rdata", dm_rdata,        32'h11223344);
    dm_req = 1'b0;
    tick();

    // Both ports held: dm wins twice, then starved fetch wins.
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 9'd0;
    if_req = 1'b1; if_addr = 9'd0;
    seq = ""; exp_seq = "DDIDDI"; cyc = 0;
    while (seq.len() < 6 && cyc < 200) begin
      tick();
      cyc++;
      if (dm_ack) seq = {seq, "D"};
      if (if_ack) seq = {seq, "I"};
    end
    total++;
    assert (seq == exp_seq) else begin
      bad++;
      $error("FAIL contention_seq observed=%s expected=%s", seq, exp_seq);
    end
    chk("contention_dm_rdata", dm_rdata, 32'h00000033);
    chk("contention_if_rdata", if_rdata, 32'h33440004);
    dm_req = 1'b0; if_req = 1'b0;
    tick();

    // clr in cycle 2 of a word store at 100.
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10; dm_addr = 9'd100; dm_wdata = 32'hAABBCCDD;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0; dm_req = 1'b0;
    quiet_outputs("clr");
    chk("clr_mem", {tb_mem[100], tb_mem[101], tb_mem[102], tb_mem[103]}, 32'hAABB0000);

    // Normal service after clr.
    if_req = 1'b1; if_addr = 9'd0;
    tick(); tick(); tick(); tick(); tick();
    chk("post_clr_ack",   {31'b0, if_ack}, 32'h1);
    chk("post_clr_rdata", if_rdata,        32'h33440004);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single byte-wide 512x8 instruction/data memory between the pipeline's fetch stage and MEM stage. Each 32-bit fetch or byte/halfword/word data access is serialized into big-endian byte beats. A `stall` output tells the hazard/control logic to freeze the pipeline until the pending access is acknowledged.

## Interface
Parameters:
- `ADDR_W`, 9: memory byte-address width (512 locations).
- `STARVE_MAX`, 2: consecutive lost arbitrations after which fetch is forced to win.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset; one clock; reset is synchronous and active-high.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid this cycle.
- `if_rdata`  out  32  fetched word.
- `dm_req`  in  1  data request; held until `dm_ack`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `dm_addr`  in  ADDR_W  data byte address.
- `dm_wdata`  in  32  store data, right-aligned.
- `dm_ack`  out  1  one-cycle completion pulse.
- `dm_rdata`  out  32  load data, zero-extended.
- `mem_addr`  out  ADDR_W  memory byte address.
- `mem_we`  out  1  memory byte write strobe.
- `mem_wdata`  out  8  memory write byte.
- `mem_rdata`  in  8  memory read byte; combinational in `mem_addr`.
- `stall`  out  1  combinational: `(if_req & ~if_ack) | (dm_req & ~dm_ack)`.

## Operation
- FSM states: IDLE, XFER, RESP.
- **IDLE**
  - Any request grants one requester.
  - The arbiter latches the winner's address, size, write enable and wdata, sets beat count = 0 and moves to XFER.
- **XFER**, one beat per cycle:
  - `mem_addr` = base + beat, modulo 2^ADDR_W.
  - Reads shift `mem_rdata` into the assembly register.
  - After the last beat the FSM moves to RESP.
  - Beat counts: word and fetch 4, halfword 2, byte 1.
- **RESP**
  - The winner's ack is high for exactly one cycle and its rdata updates.
  - The FSM returns to IDLE.
- Big-endian byte order:
  - Word read: byte at base goes to [31:24], base+3 to [7:0].
  - Halfword read: `{16'b0, M[base], M[base+1]}`.
  - Byte read: `{24'b0, M[base]}`.
- Stores:
  - Word store writes `wdata[31:24]` at base through `[7:0]` at base+3.
  - Halfword store writes `[15:8]`, then `[7:0]`.
  - Byte store writes `[7:0]`.
  - `mem_we` is high only during XFER beats of a store. Fetches never write.
- Arbitration:
  - `dm_req` beats `if_req`, unless the starvation counter equals STARVE_MAX; then fetch wins.
  - The counter increments when fetch is requesting but loses.
  - It clears when fetch is granted or `if_req` is low.
- Address rules: no alignment check. Misaligned accesses proceed, and addresses wrap 511 -> 0.
- A request dropped before its ack is still completed. The ack still pulses and is ignored.
- `mem_addr` is 0 outside XFER.
- `if_rdata` and `dm_rdata` hold their last value until the next ack of that port.

## Timing
- Request sampled high in IDLE at cycle 0:
  - Word: beats in cycles 1-4, ack in cycle 5.
  - Halfword: ack in cycle 3.
  - Byte: ack in cycle 2.
- The requester must deassert or change its request in the cycle after ack. The next grant is no earlier than that cycle (IDLE).
- Simultaneous requests in IDLE: the loser's request stays pending, and it is granted in the IDLE following the winner's RESP.
- `clr` has priority over everything. The following cycle shows:
  - State IDLE.
  - Acks, `mem_we`, `mem_wdata` and `mem_addr` at 0.
  - Both rdata registers at 0.
  - Starvation counter at 0.
- A store interrupted by `clr` leaves its already-written bytes in memory; there is no rollback.

## Structure
- Package `mips_mem_pkg` holds:
  - The size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - The FSM state enum.
  - The ADDR_W default.
- One sub-module: `mem_byte_serializer`. It owns the beat counter, address increment, read assembly shift register and write byte-lane select. The arbiter keeps only the FSM, grant logic and starvation counter.

## Test plan
- Memory preloaded with 0x8C,0x01,0x00,0x04 at 0-3; `if_req` with `if_addr` 0 -> `if_ack` in cycle 5, `if_rdata` = 0x8C010004, `stall` high in cycles 0-4.
- `dm_req` halfword load at address 2 -> `dm_ack` in cycle 3, `dm_rdata` = 0x00000004.
- `dm_req` byte store at address 511 with `dm_wdata` 0x000000AB -> one `mem_we` beat at address 511 with 0xAB; word store at 510 writes addresses 510, 511, 0, 1.
- `if_req` and `dm_req` held continuously -> grant sequence dm, dm, if, dm, dm, if.
- `clr` asserted in cycle 2 of a word store -> only addresses base and base+1 written; all outputs 0 next cycle; new request is then served normally.
